pali_seq_ctrl: RTL and testbench

//   Sequencer for palindrome detection on serially delivered words.
//   - Collects WIDTH bits over a valid/ready stream.
//   - Walks one shared bit-pair comparator across the word, one pair per cycle,

---
 rtl/pali_seq_ctrl_pkg.sv | 21 ++
 rtl/pali_pair_cmp.sv | 15 +
 rtl/pali_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pali_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pali_seq_ctrl_pkg.sv
// rtl/pali_seq_ctrl_pkg.sv - shared state encoding and sizing helper for the palindrome sequencer
//
// Purpose : FSM state encoding (IDLE=0, LOAD=1, CHECK=2, DONE=3) and an
//           index-width helper shared by the sequencer files.
// Ports   : none (package).
package pali_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits needed to address one bit of a WIDTH-bit word; never less than 1
    // so a single-bit word still has a legal index register.
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/pali_pair_cmp.sv
// rtl/pali_pair_cmp.sv - single shared bit-pair equality comparator
//
// Purpose : Combinational equality of two bits. The sequencer owns exactly one
//           instance and steps it across the word one pair per cycle.
// Ports   : i_a, i_b - bits to compare
//           o_eq     - 1 when i_a equals i_b
module pali_pair_cmp (
    input  logic i_a,
    input  logic i_b,
    output logic o_eq
);

    assign o_eq = (i_a == i_b) ? 1'b1 : 1'b0;

endmodule

// File: rtl/pali_seq_ctrl.sv
// rtl/pali_seq_ctrl.sv - serial palindrome detection sequencer with saturating hit counter
//
// Purpose : Collects WIDTH serial bits (MSB first) over a valid/ready stream,
//           walks one shared pair comparator across the word with early exit on
//           mismatch, and presents the verdict under a valid/ack handshake.
// Ports   : clk, rst_n          - clock, asynchronous active-low reset
//           start               - begin a new word (IDLE only)
//           bit_in, bit_valid   - serial data stream in
//           bit_ready           - stream accept, high in LOAD
//           busy                - high in LOAD or CHECK
//           res_valid, res_ack  - verdict handshake, valid high in DONE
//           is_pali             - verdict
//           word_out            - collected word, MSB = first bit received
//           pali_cnt            - saturating count of palindromes found
module pali_seq_ctrl
    import pali_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ack,
    output logic             is_pali,
    output logic [WIDTH-1:0] word_out,
    output logic [CNT_W-1:0] pali_cnt
);

    localparam int               IDX_W     = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_PAIR = IDX_W'((WIDTH > 1) ? (WIDTH / 2 - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_word;
    logic [IDX_W-1:0] r_bit_idx;
    logic [IDX_W-1:0] r_pair_idx;
    logic             r_is_pali;
    logic [CNT_W-1:0] r_pali_cnt;

    logic [IDX_W-1:0] w_hi_idx;
    logic             w_accept;
    logic             w_last_bit;
    logic             w_last_pair;
    logic             w_pair_eq;
    logic             w_done_enter;
    logic             w_done_pali;

    assign w_accept    = (r_state == LOAD) && bit_valid;
    assign w_last_bit  = (r_bit_idx == LAST_BIT);
    assign w_last_pair = (r_pair_idx == LAST_PAIR);
    assign w_hi_idx    = LAST_BIT - r_pair_idx;

    pali_pair_cmp u_pair_cmp (
        .i_a  (r_word[r_pair_idx]),
        .i_b  (r_word[w_hi_idx]),
        .o_eq (w_pair_eq)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; also flags the DONE entry and its verdict so the
    // datapath can latch is_pali and bump the counter on the same edge.
    always_comb begin
        w_next_state = r_state;
        w_done_enter = 1'b0;
        w_done_pali  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                if (w_accept && w_last_bit) begin
                    if (WIDTH == 1) begin
                        // A single bit is trivially a palindrome; nothing to compare.
                        w_next_state = DONE;
                        w_done_enter = 1'b1;
                        w_done_pali  = 1'b1;
                    end else begin
                        w_next_state = CHECK;
                    end
                end
            end
            CHECK: begin
                if (!w_pair_eq) begin
                    w_next_state = DONE;
                    w_done_enter = 1'b1;
                end else if (w_last_pair) begin
                    w_next_state = DONE;
                    w_done_enter = 1'b1;
                    w_done_pali  = 1'b1;
                end
            end
            DONE: begin
                // start is deliberately not looked at here; a simultaneous
                // start must be re-presented once back in IDLE.
                if (res_ack) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        bit_ready = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;
        case (r_state)
            LOAD: begin
                bit_ready = 1'b1;
                busy      = 1'b1;
            end
            CHECK: begin
                busy      = 1'b1;
            end
            DONE: begin
                res_valid = 1'b1;
            end
            default: begin
                bit_ready = 1'b0;
            end
        endcase
    end

    // Datapath: shift register, bit/pair indices, verdict and hit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word     <= '0;
            r_bit_idx  <= '0;
            r_pair_idx <= '0;
            r_is_pali  <= 1'b0;
            r_pali_cnt <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_word     <= '0;
                r_bit_idx  <= '0;
                r_pair_idx <= '0;
                r_is_pali  <= 1'b0;
            end
            if (w_accept) begin
                // Shift form keeps a WIDTH=1 word legal (no [-1:0] slice).
                r_word    <= (r_word << 1) | WIDTH'(bit_in);
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
            if ((r_state == CHECK) && w_pair_eq && !w_last_pair) begin
                r_pair_idx <= r_pair_idx + IDX_W'(1);
            end
            if (w_done_enter) begin
                r_is_pali <= w_done_pali;
                if (w_done_pali && (r_pali_cnt != CNT_MAX)) begin
                    r_pali_cnt <= r_pali_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign is_pali  = r_is_pali;
    assign word_out = r_word;
    assign pali_cnt = r_pali_cnt;

endmodule

// File: tb/tb_pali_seq_ctrl.sv
// tb/tb_pali_seq_ctrl.sv - scoreboard bench for pali_seq_ctrl (8-bit and 2-bit counter instances)
module tb_pali_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic       res_ack;

    logic       bit_ready_a, busy_a, res_valid_a, is_pali_a;
    logic [2:0] word_a;
    logic [7:0] cnt_a;
    logic       bit_ready_b, busy_b, res_valid_b, is_pali_b;
    logic [2:0] word_b;
    logic [1:0] cnt_b;

    pali_seq_ctrl #(.WIDTH(3), .CNT_W(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready_a),
        .busy      (busy_a),
        .res_valid (res_valid_a),
        .res_ack   (res_ack),
        .is_pali   (is_pali_a),
        .word_out  (word_a),
        .pali_cnt  (cnt_a)
    );

    pali_seq_ctrl #(.WIDTH(3), .CNT_W(2)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready_b),
        .busy      (busy_b),
        .res_valid (res_valid_b),
        .res_ack   (res_ack),
        .is_pali   (is_pali_b),
        .word_out  (word_b),
        .pali_cnt  (cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] word;
        logic       pal;
        logic [7:0] ca;
        logic [1:0] cb;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_ca   = 0;
    int   exp_cb   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: on each rising res_valid, pop the oldest expected verdict.
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (res_valid_a && !prev_v) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_verdict actual=word%0b required=none", word_a);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_word",    32'(word_a),      32'(e.word));
                    chk("sb_is_pali", 32'(is_pali_a),   32'(e.pal));
                    chk("sb_cnt8",    32'(cnt_a),       32'(e.ca));
                    chk("sb_cnt2",    32'(cnt_b),       32'(e.cb));
                    chk("sb_valid_b", 32'(res_valid_b), 32'd1);
                    chk("sb_pali_b",  32'(is_pali_b),   32'(e.pal));
                end
            end
            prev_v = res_valid_a;
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        res_ack   = 1'b0;
        #1;
        chk("rst_bit_ready", 32'(bit_ready_a), 32'd0);
        chk("rst_busy",      32'(busy_a),      32'd0);
        chk("rst_res_valid", 32'(res_valid_a), 32'd0);
        chk("rst_is_pali",   32'(is_pali_a),   32'd0);
        chk("rst_word",      32'(word_a),      32'd0);
        chk("rst_cnt8",      32'(cnt_a),       32'd0);
        chk("rst_cnt2",      32'(cnt_b),       32'd0);
        exp_ca = 0;
        exp_cb = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One full transaction. stall: idle cycles after the first bit.
    // hold: cycles DONE is held before ack. poke: start/res_ack driven high
    // while loading and checking. ack_start: start raised with res_ack.
    task automatic send_word(input logic [2:0] w, input int stall, input int hold,
                             input bit poke, input bit ack_start);
        exp_t e;
        int   lat;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("load_ready", 32'(bit_ready_a), 32'd1);
        e.word = w;
        e.pal  = (w[2] == w[0]);
        if (e.pal) begin
            if (exp_ca < 255) exp_ca++;
            if (exp_cb < 3)   exp_cb++;
        end
        e.ca = 8'(exp_ca);
        e.cb = 2'(exp_cb);
        sb_q.push_back(e);
        for (int i = 2; i >= 0; i--) begin
            bit_in    = w[i];
            bit_valid = 1'b1;
            start     = poke;
            res_ack   = poke;
            @(posedge clk);
            #1;
            bit_valid = 1'b0;
            if (i == 2) begin
                repeat (stall) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        chk("check_busy", 32'(busy_a), 32'd1);
        @(posedge clk);
        #1;
        start   = 1'b0;
        res_ack = 1'b0;
        lat     = 2;
        while (!res_valid_a && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'd2);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(res_valid_a), 32'd1);
            chk("hold_pali",  32'(is_pali_a),   32'(e.pal));
            chk("hold_word",  32'(word_a),      32'(w));
        end
        res_ack = 1'b1;
        start   = ack_start;
        @(posedge clk);
        #1;
        res_ack = 1'b0;
        start   = 1'b0;
        chk("ack_valid_drop", 32'(res_valid_a), 32'd0);
        chk("ack_idle_busy",  32'(busy_a),      32'd0);
        chk("ack_idle_ready", 32'(bit_ready_a), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        res_ack   = 1'b0;
        #2;
        do_reset();

        // 1: 101 back-to-back
        send_word(3'b101, 0, 0, 1'b0, 1'b0);
        chk("t1_cnt", 32'(cnt_a), 32'd1);

        // 2: 110 mismatches on the only pair
        send_word(3'b110, 0, 0, 1'b0, 1'b0);
        chk("t2_cnt", 32'(cnt_a), 32'd1);

        // 3: sweep all codes from a clean counter; one ack carries start
        do_reset();
        for (int c = 0; c < 8; c++) begin
            send_word(3'(c), 0, 0, 1'b0, (c == 3));
        end
        chk("t3_cnt8", 32'(cnt_a), 32'd4);
        chk("t3_cnt2", 32'(cnt_b), 32'd3);

        // 4: stall after the first bit
        send_word(3'b010, 3, 0, 1'b0, 1'b0);

        // 5: reset mid-LOAD, then a clean word with start/ack poked mid-word
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_in    = 1'b1;
            bit_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bit_valid = 1'b0;
        chk("t5_partial_word", 32'(word_a), 32'd3);
        do_reset();
        send_word(3'b101, 0, 0, 1'b1, 1'b0);
        chk("t5_cnt", 32'(cnt_a), 32'd1);

        // 6: five palindromes saturate the 2-bit counter; last verdict held
        do_reset();
        send_word(3'b000, 0, 0, 1'b0, 1'b0);
        send_word(3'b111, 0, 0, 1'b0, 1'b0);
        send_word(3'b010, 0, 0, 1'b0, 1'b0);
        send_word(3'b101, 0, 0, 1'b0, 1'b0);
        send_word(3'b000, 0, 4, 1'b0, 1'b0);
        chk("t6_cnt2", 32'(cnt_b), 32'd3);
        chk("t6_cnt8", 32'(cnt_a), 32'd5);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
